// File: rtl/speed_pacer_pkg.sv
// speed_pacer_pkg: shared state encoding, speed width and period function for the speed pacer.
package speed_pacer_pkg;

    localparam int unsigned SPEED_W = 3;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    // Level 7 is fastest: period shrinks linearly from 8*base down to 1*base.
    function automatic int unsigned period(input int unsigned base, input logic [SPEED_W-1:0] s);
        return base * (32'd8 - {29'd0, s});
    endfunction

endpackage

// File: rtl/speed_sync.sv
// speed_sync: 2-flop synchronizer plus a two-cycle stability filter for the asynchronous speed level.
module speed_sync
    import speed_pacer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    output logic [SPEED_W-1:0] speed_stable
);

    logic [SPEED_W-1:0] s1_q, s2_q, s3_q, stable_q;

    // Ripple edges and single-cycle glitches never show equal on two consecutive samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            stable_q <= '0;
        end else begin
            s1_q     <= speed;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            stable_q <= (s2_q == s3_q) ? s2_q : stable_q;
        end
    end

    assign speed_stable = stable_q;

endmodule

// File: rtl/speed_pacer.sv
// speed_pacer: turns a filtered speed level into evenly paced one-cycle step ticks
// and a wrapping step position; new levels take effect only at period reloads.
module speed_pacer
    import speed_pacer_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned POS_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick,
    output logic [POS_W-1:0]   position,
    output logic [SPEED_W-1:0] speed_active,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, reload;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [SPEED_W-1:0] act_q, act_d, speed_stable;
    logic               tick_q, tick_d, busy_q;

    speed_sync u_sync (
        .clk          (clk),
        .reset        (reset),
        .speed        (speed),
        .speed_stable (speed_stable)
    );

    assign reload = CNT_W'(period(BASE_PERIOD, speed_stable) - 32'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        pos_d   = pos_q;
        act_d   = act_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = enable ? LOAD : IDLE;
            end
            LOAD: begin
                act_d   = speed_stable;
                cnt_d   = reload;
                state_d = RUN;
            end
            RUN: begin
                // A dropped enable wins even on the terminal count, so no tick escapes.
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    tick_d = 1'b1;
                    pos_d  = pos_q + POS_W'(1);
                    act_d  = speed_stable;
                    cnt_d  = reload;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            pos_q   <= '0;
            act_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            pos_q   <= pos_d;
            act_q   <= act_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign tick         = tick_q;
    assign position     = pos_q;
    assign speed_active = act_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_speed_pacer.sv
// tb_speed_pacer: directed checks of tick pacing, speed reloads, glitch rejection,
// enable drop/resume, position wrap (second instance with POS_W=2) and async reset.
module tb_speed_pacer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] speed;
    logic       tick, tick2;
    logic [7:0] position;
    logic [1:0] position2;
    logic [2:0] speed_active, speed_active2;
    logic       busy, busy2;

    int checks = 0;
    int fails  = 0;
    int exp_pos = 0;
    int n;

    speed_pacer #(.BASE_PERIOD(4), .CNT_W(16), .POS_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .speed        (speed),
        .tick         (tick),
        .position     (position),
        .speed_active (speed_active),
        .busy         (busy)
    );

    speed_pacer #(.BASE_PERIOD(4), .CNT_W(16), .POS_W(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .speed        (speed),
        .tick         (tick2),
        .position     (position2),
        .speed_active (speed_active2),
        .busy         (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (tick !== 1'b1 && cnt < 100);
    endtask

    task automatic tick_seen(input string tag, input int gap_exp, input int act_exp);
        wait_tick(n);
        exp_pos++;
        check({tag, "_gap"}, n, gap_exp);
        check({tag, "_pos"}, position, exp_pos % 256);
        check({tag, "_pos2"}, position2, exp_pos % 4);
        check({tag, "_act"}, speed_active, act_exp);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        speed  = 3'd7;
        #2 reset = 1'b0;
        #1;
        check("rst_tick", tick, 0);
        check("rst_pos", position, 0);
        check("rst_act", speed_active, 0);
        check("rst_busy", busy, 0);
        repeat (3) step();
        reset = 1'b1;
        repeat (5) step();
        check("idle_busy", busy, 0);
        check("idle_tick", tick, 0);

        // Speed 7: first tick 5 edges after the sampling edge, then every 4.
        enable = 1'b1;
        step();
        check("t1_busy", busy, 1);
        tick_seen("t1_first", 5, 7);
        tick_seen("t1_second", 4, 7);
        tick_seen("t1_third", 4, 7);
        step();
        check("t1_width", tick, 0);
        tick_seen("t1_fourth", 3, 7);

        // Speed 3 applied 2 cycles after a tick: the synchronizer/filter latency
        // means the next reload still sees 7, the one after that loads 3.
        step();
        step();
        speed = 3'd3;
        tick_seen("t3_inflight", 2, 7);
        tick_seen("t3_reload", 4, 3);
        tick_seen("t3_slow", 20, 3);

        // Back to 7: the running 20-cycle period completes first.
        speed = 3'd7;
        tick_seen("t4_finish_slow", 20, 7);
        tick_seen("t4_fast", 4, 7);
        // One-cycle glitch to 2 must never reach speed_active.
        speed = 3'd2;
        step();
        speed = 3'd7;
        tick_seen("t4_glitch_a", 3, 7);
        tick_seen("t4_glitch_b", 4, 7);
        tick_seen("t4_glitch_c", 4, 7);

        // Drop enable on the terminal-count cycle.
        repeat (3) step();
        enable = 1'b0;
        step();
        check("t5_no_tick", tick, 0);
        check("t5_busy", busy, 0);
        check("t5_pos_hold", position, exp_pos % 256);
        check("t5_act_hold", speed_active, 7);
        step();
        step();
        check("t5_idle_tick", tick, 0);
        enable = 1'b1;
        step();
        check("t5_busy_again", busy, 1);
        tick_seen("t5_resume", 5, 7);

        // Slowest level: period 32.
        enable = 1'b0;
        speed  = 3'd0;
        repeat (6) step();
        enable = 1'b1;
        step();
        tick_seen("t2_first", 33, 0);
        tick_seen("t2_second", 32, 0);

        // Asynchronous reset between clock edges, right after a tick.
        #3 reset = 1'b0;
        #1;
        check("t6_rst_tick", tick, 0);
        check("t6_rst_pos", position, 0);
        check("t6_rst_pos2", position2, 0);
        check("t6_rst_act", speed_active, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_busy2", busy2, 0);
        step();
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
